// File: rtl/switch_ctrl_pkg.sv
// switch_ctrl_pkg: shared types for the switch request sequencer.
// The request struct is sized by SC_DATA_W/SC_ADDR_W; the top checks that
// its DATA_WIDTH/BYTE_ADDR_WIDTH parameters agree with them.
package switch_ctrl_pkg;
  localparam int SC_DATA_W = 16;
  localparam int SC_ADDR_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD0, ST_RD1} state_t;

  // Encoding equals the switch's source select.
  typedef enum logic {SIDE_LEFT = 1'b0, SIDE_RIGHT = 1'b1} side_t;

  typedef struct packed {
    logic                 wr;
    logic [SC_ADDR_W-1:0] addr;
    logic [SC_DATA_W-1:0] data;
  } req_t;
endpackage

// File: rtl/switch_ctrl_if.sv
// switch_ctrl_if: client request/response channels plus the switch drive bus.
// slave = sequencer side, master = clients + switch side.
interface switch_ctrl_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int BYTE_ADDR_WIDTH = 8
);
  logic                       l_req_valid, l_req_ready, l_req_wr;
  logic [BYTE_ADDR_WIDTH-1:0] l_req_addr;
  logic [DATA_WIDTH-1:0]      l_req_data;
  logic                       r_req_valid, r_req_ready, r_req_wr;
  logic [BYTE_ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0]      r_req_data;
  logic                       l_rsp_valid, r_rsp_valid;
  logic [DATA_WIDTH-1:0]      l_rsp_data, r_rsp_data;
  logic                       sw_ren, sw_wen, sw_source;
  logic [BYTE_ADDR_WIDTH-1:0] sw_addr;
  logic [DATA_WIDTH-1:0]      sw_left_i, sw_right_i, sw_rdata;

  modport slave (
    input  l_req_valid, l_req_wr, l_req_addr, l_req_data,
    input  r_req_valid, r_req_wr, r_req_addr, r_req_data, sw_rdata,
    output l_req_ready, r_req_ready, l_rsp_valid, l_rsp_data, r_rsp_valid, r_rsp_data,
    output sw_ren, sw_wen, sw_source, sw_addr, sw_left_i, sw_right_i
  );

  modport master (
    output l_req_valid, l_req_wr, l_req_addr, l_req_data,
    output r_req_valid, r_req_wr, r_req_addr, r_req_data, sw_rdata,
    input  l_req_ready, r_req_ready, l_rsp_valid, l_rsp_data, r_rsp_valid, r_rsp_data,
    input  sw_ren, sw_wen, sw_source, sw_addr, sw_left_i, sw_right_i
  );
endinterface

// File: rtl/switch_ctrl_arb.sv
// rr_arbiter2: two-requester round-robin with per-requester block.
// Index 0 = left, 1 = right; pointer resets to left.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] blk,
  output logic [1:0] gnt
);
  logic ptr_q;

  // A valid-but-blocked favoured side holds the grant back (bubble) instead
  // of passing it on; that is what keeps write streams from starving reads.
  always_comb begin
    gnt = '0;
    if (req[ptr_q]) begin
      if (!blk[ptr_q]) gnt[ptr_q] = 1'b1;
    end else if (req[~ptr_q] && !blk[~ptr_q]) begin
      gnt[~ptr_q] = 1'b1;
    end
  end

  // After a grant, favour the side that was not granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr_q <= 1'b0;
    else if (|gnt) ptr_q <= gnt[0];
  end
endmodule

// File: rtl/switch_ctrl.sv
// switch_ctrl: request sequencer driving the memory-backed switch.
// Optional stats counters: define SWITCH_CTRL_STATS_EN.
module switch_ctrl
  import switch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = SC_DATA_W,
  parameter int BYTE_ADDR_WIDTH = SC_ADDR_W,
  parameter int STAT_WIDTH      = 32
)(
  input logic          clk,
  input logic          rst_n,
  switch_ctrl_if.slave bus
`ifdef SWITCH_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_wr_cnt,
  output logic [STAT_WIDTH-1:0] stat_rd_cnt,
  output logic [STAT_WIDTH-1:0] stat_bubble_cnt
`endif
);
  if (DATA_WIDTH != SC_DATA_W || BYTE_ADDR_WIDTH != SC_ADDR_W || STAT_WIDTH < 1) begin : g_bad_cfg
    $error("switch_ctrl: widths must match switch_ctrl_pkg and STAT_WIDTH >= 1");
  end

  state_t                     state_q, state_d;
  side_t                      side_q, gside;
  logic [BYTE_ADDR_WIDTH-1:0] addr_q, nxt_addr;
  logic [1:0]                 vld, blk, gnt;
  logic                       accept;
  req_t                       l_req, r_req, sel;

  assign l_req = '{wr: bus.l_req_wr, addr: bus.l_req_addr, data: bus.l_req_data};
  assign r_req = '{wr: bus.r_req_wr, addr: bus.r_req_addr, data: bus.r_req_data};

  // Readys must stay low during reset, so valids are masked by rst_n.
  assign vld    = {bus.r_req_valid, bus.l_req_valid} & {2{rst_n}};
  // No issue from RD0; no read start while the switch commits a deferred write.
  assign blk[0] = (state_q == ST_RD0) || (state_q == ST_WR && !bus.l_req_wr);
  assign blk[1] = (state_q == ST_RD0) || (state_q == ST_WR && !bus.r_req_wr);

  rr_arbiter2 u_arb (.clk(clk), .rst_n(rst_n), .req(vld), .blk(blk), .gnt(gnt));

  assign accept          = |gnt;
  assign gside           = side_t'(gnt[1]);
  assign sel             = gnt[1] ? r_req : l_req;
  assign nxt_addr        = accept ? sel.addr : addr_q;
  assign bus.l_req_ready = gnt[0];
  assign bus.r_req_ready = gnt[1];

  // Next state: RD0 always continues to RD1, otherwise follow the grant.
  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_RD0) state_d = ST_RD1;
    else if (accept)       state_d = sel.wr ? ST_WR : ST_RD0;
  end

  // State, latched request and registered switch drive (all zero in IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      side_q         <= SIDE_LEFT;
      addr_q         <= '0;
      bus.sw_wen     <= 1'b0;
      bus.sw_ren     <= 1'b0;
      bus.sw_source  <= 1'b0;
      bus.sw_addr    <= '0;
      bus.sw_left_i  <= '0;
      bus.sw_right_i <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= sel.addr;
        side_q <= gside;
      end
      bus.sw_wen     <= (state_d == ST_WR);
      bus.sw_ren     <= (state_d == ST_RD0) || (state_d == ST_RD1);
      bus.sw_source  <= (state_d == ST_WR) && (gside == SIDE_RIGHT);
      bus.sw_addr    <= (state_d == ST_IDLE) ? '0 : nxt_addr;
      bus.sw_left_i  <= (state_d == ST_WR && gside == SIDE_LEFT)  ? sel.data : '0;
      bus.sw_right_i <= (state_d == ST_WR && gside == SIDE_RIGHT) ? sel.data : '0;
    end
  end

  // Capture read data at the end of RD1 into the requester's response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.l_rsp_valid <= 1'b0;
      bus.r_rsp_valid <= 1'b0;
      bus.l_rsp_data  <= '0;
      bus.r_rsp_data  <= '0;
    end else begin
      bus.l_rsp_valid <= (state_q == ST_RD1) && (side_q == SIDE_LEFT);
      bus.r_rsp_valid <= (state_q == ST_RD1) && (side_q == SIDE_RIGHT);
      if (state_q == ST_RD1 && side_q == SIDE_LEFT)  bus.l_rsp_data <= bus.sw_rdata;
      if (state_q == ST_RD1 && side_q == SIDE_RIGHT) bus.r_rsp_data <= bus.sw_rdata;
    end
  end

`ifdef SWITCH_CTRL_STATS_EN
  // Saturating activity counters; a bubble is a cycle with a valid request but no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_cnt     <= '0;
      stat_rd_cnt     <= '0;
      stat_bubble_cnt <= '0;
    end else begin
      if (accept && sel.wr && stat_wr_cnt != '1)   stat_wr_cnt <= stat_wr_cnt + 1'b1;
      if (accept && !sel.wr && stat_rd_cnt != '1)  stat_rd_cnt <= stat_rd_cnt + 1'b1;
      if (|vld && !accept && stat_bubble_cnt != '1) stat_bubble_cnt <= stat_bubble_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_switch_ctrl.sv
// tb_switch_ctrl: scoreboard bench for switch_ctrl with a behavioural switch
// (deferred write commit, registered two-cycle read).
module tb_switch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  switch_ctrl_if #(.DATA_WIDTH(16), .BYTE_ADDR_WIDTH(8)) bus ();

`ifdef SWITCH_CTRL_STATS_EN
  logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_bubble_cnt;
  switch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                   .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
                   .stat_bubble_cnt(stat_bubble_cnt));
`else
  switch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // Switch model: write presented with wen commits one edge later;
  // dout registers mem[addr] each ren cycle and shows on rdata while ren.
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  logic        pend_v = 1'b0;
  logic [7:0]  pend_a = '0;
  logic [15:0] pend_d = '0, dout = '0;
  initial for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
  always @(posedge clk) begin
    if (pend_v) mem[pend_a] <= pend_d;
    pend_v <= bus.sw_wen;
    pend_a <= bus.sw_addr;
    pend_d <= bus.sw_source ? bus.sw_right_i : bus.sw_left_i;
    if (bus.sw_ren) dout <= mem[bus.sw_addr];
  end
  assign bus.sw_rdata = bus.sw_ren ? dout : 16'h0;

  typedef struct { int cyc; bit side; logic [7:0] addr; logic [15:0] data; } exp_t;
  exp_t exp_wr[$];
  exp_t exp_rsp[$];
  bit   glog_side[$];
  int   glog_cyc[$];
  int   l_pulses = 0, r_pulses = 0, n_wr = 0, n_rd = 0;

  // Monitor: compare DUT outputs against queued expectations, then queue new ones.
  always @(negedge clk) begin
    exp_t e;
    if (bus.l_rsp_valid) l_pulses++;
    if (bus.r_rsp_valid) r_pulses++;
    if (rst_n) begin
      if (bus.sw_wen) begin
        vectors++;
        if (exp_wr.size() == 0) begin
          miscompares++;
          $display("FAIL sw_wen_unexpected cyc=%0d got wen=1 want wen=0", cyc);
        end else begin
          e = exp_wr.pop_front();
          if ({cyc, bus.sw_source, bus.sw_addr, bus.sw_left_i, bus.sw_right_i} !==
              {e.cyc, e.side, e.addr, e.side ? 16'h0 : e.data, e.side ? e.data : 16'h0}) begin
            miscompares++;
            $display("FAIL sw_write got cyc=%0d src=%0d addr=%h l=%h r=%h want cyc=%0d src=%0d addr=%h data=%h",
                     cyc, bus.sw_source, bus.sw_addr, bus.sw_left_i, bus.sw_right_i, e.cyc, e.side, e.addr, e.data);
          end
        end
      end
      if (bus.l_rsp_valid || bus.r_rsp_valid) begin
        vectors++;
        if (exp_rsp.size() == 0 || (bus.l_rsp_valid && bus.r_rsp_valid)) begin
          miscompares++;
          $display("FAIL rsp_unexpected cyc=%0d got l=%0d r=%0d want none", cyc, bus.l_rsp_valid, bus.r_rsp_valid);
        end else begin
          e = exp_rsp.pop_front();
          if ({cyc, bus.r_rsp_valid, e.side ? bus.r_rsp_data : bus.l_rsp_data} !== {e.cyc, e.side, e.data}) begin
            miscompares++;
            $display("FAIL rsp got cyc=%0d side=%0d data=%h want cyc=%0d side=%0d data=%h", cyc, bus.r_rsp_valid,
                     e.side ? bus.r_rsp_data : bus.l_rsp_data, e.cyc, e.side, e.data);
          end
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (s == 0 ? (bus.l_req_valid && bus.l_req_ready) : (bus.r_req_valid && bus.r_req_ready)) begin
          e.side = (s == 1);
          e.addr = e.side ? bus.r_req_addr : bus.l_req_addr;
          glog_side.push_back(e.side);
          glog_cyc.push_back(cyc);
          if (e.side ? bus.r_req_wr : bus.l_req_wr) begin
            e.data = e.side ? bus.r_req_data : bus.l_req_data;
            e.cyc  = cyc + 1;
            ref_mem[e.addr] = e.data;
            exp_wr.push_back(e);
            n_wr++;
          end else begin
            e.data = ref_mem[e.addr];
            e.cyc  = cyc + 3;
            exp_rsp.push_back(e);
            n_rd++;
          end
        end
      end
    end
  end

  // Present a request from posedge+1 and hold it until accepted (bounded).
  task automatic drive(input bit side, input bit wr, input logic [7:0] a, input logic [15:0] d, output int acc);
    acc = -1;
    if (side) begin bus.r_req_valid = 1; bus.r_req_wr = wr; bus.r_req_addr = a; bus.r_req_data = d; end
    else      begin bus.l_req_valid = 1; bus.l_req_wr = wr; bus.l_req_addr = a; bus.l_req_data = d; end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (side ? bus.r_req_ready : bus.l_req_ready) begin acc = cyc; break; end
    end
    @(posedge clk); #1;
    if (side) bus.r_req_valid = 0; else bus.l_req_valid = 0;
    vectors++;
    if (acc < 0) begin
      miscompares++;
      $display("FAIL req_timeout side=%0d got no ready want ready within 40 cycles", side);
    end
  endtask

  // Wait (bounded) for a response pulse; returns at posedge+1.
  task automatic wait_rsp(input bit side, output int c, output logic [15:0] d);
    c = -1; d = 'x;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (side ? bus.r_rsp_valid : bus.l_rsp_valid) begin
        c = cyc; d = side ? bus.r_rsp_data : bus.l_rsp_data; break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.l_req_valid = 1; bus.l_req_wr = 1; bus.l_req_addr = 8'h01; bus.l_req_data = 16'h1111;
    bus.r_req_valid = 1; bus.r_req_wr = 0; bus.r_req_addr = 8'h02; bus.r_req_data = 16'h0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.l_req_ready, bus.r_req_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 00", {bus.l_req_ready, bus.r_req_ready});
    end
    vectors++;
    if ({bus.sw_ren, bus.sw_wen, bus.sw_source, bus.sw_addr, bus.sw_left_i, bus.sw_right_i,
         bus.l_rsp_valid, bus.r_rsp_valid, bus.l_rsp_data, bus.r_rsp_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got nonzero want all zero");
    end
    bus.l_req_valid = 0; bus.r_req_valid = 0;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_left_wr_rd();
    int aw, ar, c; logic [15:0] d;
    drive(0, 1, 8'h10, 16'hBEEF, aw);
    drive(0, 0, 8'h10, 16'h0, ar);
    vectors++;
    if (ar !== aw + 2) begin miscompares++; $display("FAIL left_rd_accept got %0d want %0d", ar, aw + 2); end
    wait_rsp(0, c, d);
    vectors++;
    if ({c, d} !== {ar + 3, 16'hBEEF}) begin
      miscompares++; $display("FAIL left_rd_data got cyc=%0d data=%h want cyc=%0d data=beef", c, d, ar + 3);
    end
  endtask

  task automatic test_right_wr_rd();
    int aw, ar, c, lp; logic [15:0] d;
    lp = l_pulses;
    drive(1, 1, 8'h05, 16'h1234, aw);
    drive(1, 0, 8'h05, 16'h0, ar);
    wait_rsp(1, c, d);
    vectors++;
    if ({c, d} !== {ar + 3, 16'h1234}) begin
      miscompares++; $display("FAIL right_rd_data got cyc=%0d data=%h want cyc=%0d data=1234", c, d, ar + 3);
    end
    vectors++;
    if (l_pulses !== lp) begin miscompares++; $display("FAIL right_no_l_rsp got %0d want %0d", l_pulses, lp); end
  endtask

  task automatic test_rd_rd();
    int a0, a1, c; logic [15:0] d;
    fork
      drive(0, 0, 8'h10, 16'h0, a0);
      begin @(negedge clk); #1; drive(1, 0, 8'h05, 16'h0, a1); end
    join
    vectors++;
    if (a1 - a0 !== 2) begin miscompares++; $display("FAIL rd_rd_spacing got %0d want 2", a1 - a0); end
    wait_rsp(1, c, d);
    vectors++;
    if (d !== 16'h1234) begin miscompares++; $display("FAIL rd_rd_data got %h want 1234", d); end
  endtask

  task automatic test_back_to_back();
    int a;
    glog_side.delete(); glog_cyc.delete();
    fork
      for (int i = 0; i < 4; i++) drive(0, 1, 8'h40 + 8'(i), 16'h1000 + 16'(i), a);
      for (int i = 0; i < 4; i++) drive(1, 1, 8'h50 + 8'(i), 16'h2000 + 16'(i), a);
    join
    vectors++;
    if (glog_cyc.size() !== 8) begin
      miscompares++; $display("FAIL b2b_grants got %0d want 8", glog_cyc.size());
    end else begin
      vectors++;
      if (glog_cyc[7] - glog_cyc[0] !== 7) begin
        miscompares++; $display("FAIL b2b_span got %0d want 7", glog_cyc[7] - glog_cyc[0]);
      end
      for (int i = 1; i < 8; i++) begin
        vectors++;
        if (glog_side[i] === glog_side[i-1]) begin
          miscompares++; $display("FAIL b2b_alternate idx=%0d got side=%0d want side=%0d", i, glog_side[i], !glog_side[i-1]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_starvation();
    int a, ar, st;
`ifdef SWITCH_CTRL_STATS_EN
    logic [31:0] b0;
    b0 = stat_bubble_cnt;
`endif
    st = cyc;
    fork
      for (int i = 0; i < 5; i++) drive(0, 1, 8'h60 + 8'(i), 16'hC000 + 16'(i), a);
      drive(1, 0, 8'h60, 16'h0, ar);
    join
    vectors++;
    if (ar - st > 2) begin miscompares++; $display("FAIL starve_wait got %0d want <=2", ar - st); end
    idle(6);
`ifdef SWITCH_CTRL_STATS_EN
    vectors++;
    if (!(stat_bubble_cnt > b0)) begin
      miscompares++; $display("FAIL stat_bubble got %0d want >%0d", stat_bubble_cnt, b0);
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    int a, ar, lp, rp, c; logic [15:0] d;
    drive(0, 1, 8'h30, 16'hA5A5, a);
    idle(2);
    drive(0, 0, 8'h30, 16'h0, ar);
    @(posedge clk); #2;
    rst_n = 0;
    exp_rsp.delete(); exp_wr.delete();
    n_wr = 0; n_rd = 0;
    #1;
    vectors++;
    if ({bus.sw_ren, bus.sw_wen, bus.sw_source, bus.sw_addr, bus.sw_left_i, bus.sw_right_i,
         bus.l_rsp_valid, bus.r_rsp_valid, bus.l_req_ready, bus.r_req_ready} !== '0) begin
      miscompares++; $display("FAIL async_reset_outputs got nonzero want all zero");
    end
    lp = l_pulses; rp = r_pulses;
    repeat (3) @(negedge clk);
    rst_n = 1;
    idle(3);
    vectors++;
    if ({l_pulses, r_pulses} !== {lp, rp}) begin
      miscompares++; $display("FAIL reset_rsp_discard got l=%0d r=%0d want l=%0d r=%0d", l_pulses, r_pulses, lp, rp);
    end
    drive(0, 0, 8'h30, 16'h0, ar);
    wait_rsp(0, c, d);
    vectors++;
    if (d !== 16'hA5A5) begin miscompares++; $display("FAIL post_reset_rd got %h want a5a5", d); end
  endtask

`ifdef SWITCH_CTRL_STATS_EN
  task automatic test_stats();
    idle(2);
    vectors++;
    if ({stat_wr_cnt, stat_rd_cnt} !== {32'(n_wr), 32'(n_rd)}) begin
      miscompares++; $display("FAIL stat_counts got wr=%0d rd=%0d want wr=%0d rd=%0d", stat_wr_cnt, stat_rd_cnt, n_wr, n_rd);
    end
  endtask
`endif

  initial begin
    bus.l_req_valid = 0; bus.l_req_wr = 0; bus.l_req_addr = '0; bus.l_req_data = '0;
    bus.r_req_valid = 0; bus.r_req_wr = 0; bus.r_req_addr = '0; bus.r_req_data = '0;
    test_reset();
    test_left_wr_rd();
    test_right_wr_rd();
    test_rd_rd();
    test_back_to_back();
    test_starvation();
    test_reset_mid_read();
    idle(2);
    test_left_wr_rd();
`ifdef SWITCH_CTRL_STATS_EN
    test_stats();
`endif
    idle(6);
    vectors++;
    if (exp_wr.size() + exp_rsp.size() !== 0) begin
      miscompares++; $display("FAIL drain got wr=%0d rsp=%0d pending want 0", exp_wr.size(), exp_rsp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
